// File: rtl/tcs3200_pkg.sv
// tcs3200_pkg: filter codes, FSM states and channel indices shared by the TCS3200 sampler.
package tcs3200_pkg;

    // Filter select codes driven as {s2, s3}.
    localparam logic [1:0] FILT_R     = 2'b00;
    localparam logic [1:0] FILT_B     = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;
    localparam logic [1:0] FILT_G     = 2'b11;

    typedef logic [1:0] ch_t;
    localparam ch_t CH_R     = 2'd0;
    localparam ch_t CH_G     = 2'd1;
    localparam ch_t CH_B     = 2'd2;
    localparam ch_t CH_CLEAR = 2'd3;

    localparam int NORM_MAX = 1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_STORE,
        ST_NORM,
        ST_DONE
    } state_t;

    function automatic logic [1:0] filt_code(input ch_t ch);
        case (ch)
            CH_R:    return FILT_R;
            CH_G:    return FILT_G;
            CH_B:    return FILT_B;
            default: return FILT_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/tcs3200_rgb_sampler_pulse_sync_edge.sv
// pulse_sync_edge: 2-FF synchroniser for an asynchronous input followed by a rising-edge detector.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [2:0] sync;

    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[1:0], din};
    end

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/tcs3200_rgb_sampler_seq_divider.sv
// seq_divider: restoring divider producing floor(num * 2^W / den) for num < den, one bit per cycle.
// Only instantiated when CLEAR_NORM_EN is defined; the caller filters num >= den and den == 0.
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic [W-1:0] quo,
    output logic         done
);

    localparam int SW = $clog2(W);

    logic [W-1:0]  rem;
    logic [W-1:0]  dsr;
    logic [SW-1:0] step;
    logic          active;
    logic [W:0]    rem2;

    assign rem2 = {rem, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem    <= '0;
            dsr    <= '0;
            quo    <= '0;
            step   <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem    <= num;
                dsr    <= den;
                quo    <= '0;
                step   <= '0;
                active <= 1'b1;
            end else if (active) begin
                if (rem2 >= {1'b0, dsr}) begin
                    rem <= W'(rem2 - {1'b0, dsr});
                    quo <= {quo[W-2:0], 1'b1};
                end else begin
                    rem <= rem2[W-1:0];
                    quo <= {quo[W-2:0], 1'b0};
                end
                step <= step + 1'b1;
                if (step == SW'(W - 1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tcs3200_rgb_sampler.sv
// tcs3200_rgb_sampler: steps a TCS3200 through R, G, B filters and counts sensor pulses per gate window.
// Define CLEAR_NORM_EN to add a CLEAR channel and normalise each colour to min(1023, count*1024/clear).
module tcs3200_rgb_sampler
    import tcs3200_pkg::*;
#(
    parameter int GATE_CYCLES   = 500000,
    parameter int SETTLE_CYCLES = 5000,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sensor_out,
    output logic        s2,
    output logic        s3,
    output logic [15:0] red_norm,
    output logic [15:0] green_norm,
    output logic [15:0] blue_norm,
    output logic        valid,
    output logic        busy
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
`ifdef CLEAR_NORM_EN
    localparam ch_t LAST_CH = CH_CLEAR;
`else
    localparam ch_t LAST_CH = CH_B;
`endif

    state_t           state, next_state;
    ch_t              ch;
    logic [TW-1:0]    timer;
    logic             timer_last;
    logic [CNT_W-1:0] cnt, sh_r, sh_g;
    logic             rise;
    logic             publish;

    pulse_sync_edge u_sync (.clk(clk), .rst(rst), .din(sensor_out), .rise(rise));

`ifdef CLEAR_NORM_EN
    logic [CNT_W-1:0] sh_b, sh_c, div_num, div_den, div_quo;
    logic [1:0]       div_sel, div_idx;
    logic             div_start, div_done;
    logic [15:0]      norm_r, norm_g;

    function automatic logic [15:0] norm_val(input logic [CNT_W-1:0] num, den, quo);
        if (den == '0)       return '0;
        else if (num >= den) return 16'(NORM_MAX);
        else                 return 16'(quo >> (CNT_W - 10));
    endfunction

    // The first division starts in STORE, before sh_c is written, so it takes the clear count live.
    assign div_start = (state == ST_STORE && ch == CH_CLEAR) ||
                       (state == ST_NORM && div_done && div_sel != 2'd2);
    assign div_idx   = (state == ST_STORE) ? 2'd0 : div_sel + 2'd1;
    assign div_den   = (state == ST_STORE) ? cnt : sh_c;
    assign div_num   = (div_idx == 2'd0) ? sh_r : (div_idx == 2'd1) ? sh_g : sh_b;

    seq_divider #(.W(CNT_W)) u_div (
        .clk(clk), .rst(rst), .start(div_start), .num(div_num), .den(div_den),
        .quo(div_quo), .done(div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_sel <= '0;
            norm_r  <= '0;
            norm_g  <= '0;
        end else if (state == ST_STORE) begin
            div_sel <= '0;
        end else if (state == ST_NORM && div_done) begin
            if (div_sel == 2'd0) norm_r <= norm_val(sh_r, sh_c, div_quo);
            if (div_sel == 2'd1) norm_g <= norm_val(sh_g, sh_c, div_quo);
            div_sel <= div_sel + 2'd1;
        end
    end
`endif

    assign timer_last = (state == ST_SETTLE && timer == TW'(SETTLE_CYCLES - 1)) ||
                        (state == ST_GATE   && timer == TW'(GATE_CYCLES - 1));
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
    always_comb begin
        next_state = state;
        publish    = 1'b0;
        case (state)
            ST_IDLE:   if (enable) next_state = ST_SETTLE;
            ST_SETTLE: if (timer_last) next_state = ST_GATE;
            ST_GATE:   if (timer_last) next_state = ST_STORE;
            ST_STORE: begin
                if (ch != LAST_CH) next_state = ST_SETTLE;
`ifdef CLEAR_NORM_EN
                else next_state = ST_NORM;
`else
                else begin
                    next_state = ST_DONE;
                    publish    = 1'b1;
                end
`endif
            end
`ifdef CLEAR_NORM_EN
            ST_NORM: if (div_done && div_sel == 2'd2) begin
                next_state = ST_DONE;
                publish    = 1'b1;
            end
`endif
            ST_DONE:   next_state = enable ? ST_SETTLE : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs and valid load together on entry to DONE, so valid marks a cycle showing the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer      <= '0;
            cnt        <= '0;
            ch         <= CH_R;
            {s2, s3}   <= FILT_R;
            sh_r       <= '0;
            sh_g       <= '0;
`ifdef CLEAR_NORM_EN
            sh_b       <= '0;
            sh_c       <= '0;
`endif
            red_norm   <= '0;
            green_norm <= '0;
            blue_norm  <= '0;
            valid      <= 1'b0;
        end else begin
            valid <= publish;

            if ((state == ST_SETTLE || state == ST_GATE) && !timer_last) timer <= timer + 1'b1;
            else                                                          timer <= '0;

            if (state == ST_GATE) begin
                if (rise && cnt != '1) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            if ((state == ST_IDLE || state == ST_DONE) && enable) begin
                ch       <= CH_R;
                {s2, s3} <= FILT_R;
            end else if (state == ST_STORE && ch != LAST_CH) begin
                ch       <= ch + 2'd1;
                {s2, s3} <= filt_code(ch + 2'd1);
            end

            if (state == ST_STORE) begin
                case (ch)
                    CH_R: sh_r <= cnt;
                    CH_G: sh_g <= cnt;
`ifdef CLEAR_NORM_EN
                    CH_B: sh_b <= cnt;
                    CH_CLEAR: sh_c <= cnt;
`endif
                    default: ;
                endcase
            end

            if (publish) begin
`ifdef CLEAR_NORM_EN
                red_norm   <= norm_r;
                green_norm <= norm_g;
                blue_norm  <= norm_val(sh_b, sh_c, div_quo);
`else
                red_norm   <= 16'(sh_r);
                green_norm <= 16'(sh_g);
                blue_norm  <= 16'(cnt);
`endif
            end
        end
    end

endmodule
